// File: rtl/eth_pkg.sv
// eth_pkg
//   Shared definitions for the Ethernet receive CRC checker:
//   CRC-32 constants, the per-byte CRC update function and the
//   frame-tracking state enum.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Remainder left in the register after data plus a correct FCS has been
  // folded in (non-reflected register bit order, no final complement).
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_e;

  // One byte through the CRC register, bit 0 first (the wire order of the
  // MAC). The register is kept MSB-first so the residue matches the
  // classic 0xC704DD7B constant.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC32_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_lane_fold.sv
// crc32_lane_fold
//   Combinational fold of up to LANES bytes into a CRC-32 remainder.
//   Lane 0 is folded first; only lanes below nbytes_i take part.
// Ports
//   crc_i     remainder before this beat
//   data_i    LANES bytes, lane 0 in [7:0]
//   nbytes_i  number of lanes to fold (1..LANES)
//   crc_o     remainder after this beat
module crc32_lane_fold
  import eth_pkg::*;
#(
  parameter  int LANES = 1,
  localparam int KW    = $clog2(LANES) + 1
) (
  input  logic [31:0]        crc_i,
  input  logic [8*LANES-1:0] data_i,
  input  logic [KW-1:0]      nbytes_i,
  output logic [31:0]        crc_o
);

  // One byte stage per lane; a disabled lane passes its input through so
  // a short eof beat leaves the trailing lanes out of the remainder.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] c_in;
    logic [31:0] c_out;
    if (g == 0) begin : g_head
      assign c_in = crc_i;
    end else begin : g_link
      assign c_in = g_lane[g-1].c_out;
    end
    assign c_out = (KW'(g) < nbytes_i) ? crc32_byte(c_in, data_i[8*g +: 8])
                                       : c_in;
  end

  assign crc_o = g_lane[LANES-1].c_out;

endmodule

// File: rtl/eth_crc32_rx_chk.sv
// eth_crc32_rx_chk
//   Receive-side Ethernet frame checker. Folds 1, 2 or 4 bytes per beat into
//   a CRC-32 remainder, counts frame length and produces one registered
//   status record per terminated frame (good eof or abort by a new sof).
// Ports
//   sclk, resetb       clock, asynchronous active-low reset
//   in_valid           beat qualifier
//   in_sof / in_eof    first / last beat of a frame (with in_valid)
//   in_keep            valid bytes on an eof beat, 0 means LANES
//   din                beat data, lane 0 = din[7:0] is earliest on the wire
//   st_valid           one-cycle pulse per terminated frame
//   st_crc_ok          remainder matched the good-frame residue
//   st_runt/st_giant   length below MIN_LEN / above MAX_LEN
//   st_abort           frame cut short by a new sof
//   st_len             byte count including FCS, saturating
//   busy               a frame is in progress
module eth_crc32_rx_chk
  import eth_pkg::*;
#(
  parameter  int LANES   = 1,
  parameter  int MIN_LEN = 64,
  parameter  int MAX_LEN = 1518,
  parameter  int LEN_W   = 14,
  localparam int KW      = $clog2(LANES) + 1
) (
  input  logic               sclk,
  input  logic               resetb,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic               in_eof,
  input  logic [KW-1:0]      in_keep,
  input  logic [8*LANES-1:0] din,
  output logic               st_valid,
  output logic               st_crc_ok,
  output logic               st_runt,
  output logic               st_giant,
  output logic               st_abort,
  output logic [LEN_W-1:0]   st_len,
  output logic               busy
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [KW-1:0]    FULL  = KW'(LANES);

  state_e             state_q, state_d;
  logic [31:0]        crc_q, crc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               giant_q, giant_d;

  logic               stv_q, stv_d;
  logic               ok_q, ok_d;
  logic               runt_q, runt_d;
  logic               sgiant_q, sgiant_d;
  logic               abort_q, abort_d;
  logic [LEN_W-1:0]   slen_q, slen_d;

  // Bytes carried by this beat. Out-of-range keep counts are treated as a
  // full beat so the CRC and length never disagree.
  logic [KW-1:0]      beat_n;
  always_comb begin
    beat_n = FULL;
    if (in_eof && in_keep != '0 && in_keep <= FULL) beat_n = in_keep;
  end

  // A sof beat always starts from the seed, regardless of what the
  // registers hold (this also covers the restart after an abort).
  logic [31:0]        crc_seed, crc_new;
  logic [LEN_W-1:0]   len_base, len_new;
  logic [LEN_W:0]     len_sum;
  logic               giant_new;

  assign crc_seed = in_sof ? CRC32_INIT : crc_q;
  assign len_base = in_sof ? '0 : len_q;
  assign len_sum  = {1'b0, len_base} + (LEN_W+1)'(beat_n);
  // At most LANES bytes are added to a saturated count, so overflow can
  // only show up in the extra top bit.
  assign len_new  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  assign giant_new = (giant_q & ~in_sof) | (len_new > MAX_L);

  crc32_lane_fold #(.LANES(LANES)) u_fold (
    .crc_i    (crc_seed),
    .data_i   (din),
    .nbytes_i (beat_n),
    .crc_o    (crc_new)
  );

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    len_d    = len_q;
    giant_d  = giant_q;
    stv_d    = 1'b0;
    ok_d     = ok_q;
    runt_d   = runt_q;
    sgiant_d = sgiant_q;
    abort_d  = abort_q;
    slen_d   = slen_q;

    if (in_valid) begin
      if (in_eof && (in_sof || state_q == FRAME)) begin
        // Frame ends on this beat (single-beat frames included).
        stv_d    = 1'b1;
        ok_d     = (crc_new == CRC32_RESIDUE);
        runt_d   = (len_new < MIN_L);
        sgiant_d = giant_new;
        abort_d  = 1'b0;
        slen_d   = len_new;
        state_d  = IDLE;
        crc_d    = CRC32_INIT;
        len_d    = '0;
        giant_d  = 1'b0;
      end else if (in_sof) begin
        if (state_q == FRAME) begin
          // Old frame never saw its eof: report it from the held counters.
          stv_d    = 1'b1;
          ok_d     = 1'b0;
          runt_d   = (len_q < MIN_L);
          sgiant_d = giant_q;
          abort_d  = 1'b1;
          slen_d   = len_q;
        end
        state_d = FRAME;
        crc_d   = crc_new;
        len_d   = len_new;
        giant_d = giant_new;
      end else if (state_q == FRAME) begin
        crc_d   = crc_new;
        len_d   = len_new;
        giant_d = giant_new;
      end
      // IDLE beats without sof fall through and are dropped.
    end
  end

  always_ff @(posedge sclk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      crc_q    <= CRC32_INIT;
      len_q    <= '0;
      giant_q  <= 1'b0;
      stv_q    <= 1'b0;
      ok_q     <= 1'b0;
      runt_q   <= 1'b0;
      sgiant_q <= 1'b0;
      abort_q  <= 1'b0;
      slen_q   <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      giant_q  <= giant_d;
      stv_q    <= stv_d;
      ok_q     <= ok_d;
      runt_q   <= runt_d;
      sgiant_q <= sgiant_d;
      abort_q  <= abort_d;
      slen_q   <= slen_d;
    end
  end

  assign st_valid  = stv_q;
  assign st_crc_ok = ok_q;
  assign st_runt   = runt_q;
  assign st_giant  = sgiant_q;
  assign st_abort  = abort_q;
  assign st_len    = slen_q;
  assign busy      = (state_q == FRAME);

endmodule

// File: tb/tb_eth_crc32_rx_chk.sv
module tb_eth_crc32_rx_chk;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;
  logic resetb;

  logic        v1, s1, e1;
  logic [0:0]  k1;
  logic [7:0]  d1;
  logic        sv1, ok1, ru1, gi1, ab1, bz1;
  logic [13:0] ln1;

  logic        v4, s4, e4;
  logic [2:0]  k4;
  logic [31:0] d4;
  logic        sv4, ok4, ru4, gi4, ab4, bz4;
  logic [13:0] ln4;

  eth_crc32_rx_chk #(.LANES(1)) u_dut1 (
    .sclk(sclk), .resetb(resetb), .in_valid(v1), .in_sof(s1), .in_eof(e1),
    .in_keep(k1), .din(d1), .st_valid(sv1), .st_crc_ok(ok1), .st_runt(ru1),
    .st_giant(gi1), .st_abort(ab1), .st_len(ln1), .busy(bz1));

  eth_crc32_rx_chk #(.LANES(4)) u_dut4 (
    .sclk(sclk), .resetb(resetb), .in_valid(v4), .in_sof(s4), .in_eof(e4),
    .in_keep(k4), .din(d4), .st_valid(sv4), .st_crc_ok(ok4), .st_runt(ru4),
    .st_giant(gi4), .st_abort(ab4), .st_len(ln4), .busy(bz4));

  typedef struct {
    bit ok; bit runt; bit giant; bit abort; int len; int cyc;
  } stat_t;

  typedef struct {
    int lanes; int n; bit bad; bit gaps;
    bit exp_ok; int exp_len; bit exp_runt; bit exp_giant;
  } vec_t;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int first_cyc, last_cyc;
  bit [7:0] frm[$];
  stat_t mq1[$], mq4[$];

  always @(posedge sclk) cyc <= cyc + 1;

  // Status monitors: every cycle with st_valid high is one record, so a
  // stretched pulse shows up as an extra record.
  always @(negedge sclk) begin
    if (sv1 === 1'b1) mq1.push_back('{ok1, ru1, gi1, ab1, int'(ln1), cyc});
    if (sv4 === 1'b1) mq4.push_back('{ok4, ru4, gi4, ab4, int'(ln4), cyc});
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic stat_t mk(bit ok, bit runt, bit giant, bit abort, int len);
    stat_t s;
    s.ok = ok; s.runt = runt; s.giant = giant; s.abort = abort;
    s.len = len; s.cyc = 0;
    return s;
  endfunction

  // Standard reflected CRC-32 of the first n frame bytes (IEEE 802.3 FCS).
  function automatic bit [31:0] crc_std(int n);
    bit [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic append_fcs();
    bit [31:0] c;
    c = crc_std(frm.size());
    frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
    frm.push_back(c[23:16]); frm.push_back(c[31:24]);
  endtask

  // Build an n-byte frame (FCS included) with a correct FCS.
  task automatic build(input int n, input bit rnd);
    frm.delete();
    for (int i = 0; i < n - 4; i++)
      frm.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i * 7 + 3));
    append_fcs();
  endtask

  // Frame-level reference: a good frame is one whose last four bytes are
  // the FCS of everything before them.
  function automatic stat_t model();
    stat_t s;
    int n = frm.size();
    s.len   = (n > 16383) ? 16383 : n;
    s.runt  = (n < 64);
    s.giant = (n > 1518);
    s.abort = 1'b0;
    s.ok    = (n >= 4) && ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == crc_std(n - 4));
    s.cyc   = 0;
    return s;
  endfunction

  task automatic idle_inputs();
    v1 = 0; s1 = 0; e1 = 0; k1 = 1'b1; d1 = 8'h0;
    v4 = 0; s4 = 0; e4 = 0; k4 = 3'd4; d4 = 32'h0;
  endtask

  task automatic drive(input int lanes, input bit gaps, input bit do_eof);
    int n  = frm.size();
    int nb = (n + lanes - 1) / lanes;
    for (int b = 0; b < nb; b++) begin
      int rem = n - b * lanes;
      bit last = (b == nb - 1);
      logic [31:0] w = $urandom();
      for (int l = 0; l < lanes; l++) if (l < rem) w[8*l +: 8] = frm[b*lanes + l];
      if (lanes == 1) begin
        v1 = 1; s1 = (b == 0); e1 = do_eof && last;
        k1 = 1'($urandom_range(0, 1)); d1 = w[7:0];
      end else begin
        v4 = 1; s4 = (b == 0); e4 = do_eof && last; d4 = w;
        if (e4 && rem < 4) k4 = 3'(rem);
        else if (e4)       k4 = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd0;
        else               k4 = 3'd4;
      end
      @(posedge sclk); #1;
      if (b == 0) first_cyc = cyc;
      if (last)   last_cyc  = cyc;
      if (gaps && !last) begin
        // Junk markers with valid low must be ignored.
        v1 = 0; v4 = 0; s1 = 1; s4 = 1; e1 = 1; e4 = 1;
        d1 = 8'($urandom()); d4 = $urandom();
        @(posedge sclk); #1;
      end
    end
    idle_inputs();
  endtask

  function automatic int qsize(int lanes);
    return (lanes == 1) ? mq1.size() : mq4.size();
  endfunction

  task automatic check_st(input int lanes, input string nm, input stat_t e, input int ecyc);
    stat_t a;
    int t = 0;
    while (qsize(lanes) == 0 && t < 20) begin @(posedge sclk); #1; t++; end
    if (qsize(lanes) == 0) begin
      checks++; fails++;
      $display("FAIL %s.timeout actual=no_status expected=status", nm);
    end else begin
      a = (lanes == 1) ? mq1.pop_front() : mq4.pop_front();
      cmp({nm, ".ok"},    int'(a.ok),    int'(e.ok));
      cmp({nm, ".runt"},  int'(a.runt),  int'(e.runt));
      cmp({nm, ".giant"}, int'(a.giant), int'(e.giant));
      cmp({nm, ".abort"}, int'(a.abort), int'(e.abort));
      cmp({nm, ".len"},   a.len,         e.len);
      if (ecyc >= 0) cmp({nm, ".cyc"}, a.cyc, ecyc);
    end
  endtask

  vec_t tbl[11];

  initial begin
    stat_t e;
    int c1, lanes, n;
    bit bad, gaps;

    tbl[0]  = '{1, 64,    1'b0, 1'b0, 1'b1, 64,    1'b0, 1'b0};
    tbl[1]  = '{4, 64,    1'b0, 1'b1, 1'b1, 64,    1'b0, 1'b0};
    tbl[2]  = '{4, 63,    1'b0, 1'b0, 1'b1, 63,    1'b1, 1'b0};
    tbl[3]  = '{4, 65,    1'b0, 1'b0, 1'b1, 65,    1'b0, 1'b0};
    tbl[4]  = '{4, 66,    1'b0, 1'b1, 1'b1, 66,    1'b0, 1'b0};
    tbl[5]  = '{4, 67,    1'b0, 1'b0, 1'b1, 67,    1'b0, 1'b0};
    tbl[6]  = '{4, 1518,  1'b0, 1'b0, 1'b1, 1518,  1'b0, 1'b0};
    tbl[7]  = '{4, 1519,  1'b1, 1'b0, 1'b0, 1519,  1'b0, 1'b1};
    tbl[8]  = '{1, 5,     1'b1, 1'b0, 1'b0, 5,     1'b1, 1'b0};
    tbl[9]  = '{4, 4,     1'b0, 1'b0, 1'b1, 4,     1'b1, 1'b0};
    tbl[10] = '{4, 16400, 1'b0, 1'b0, 1'b1, 16383, 1'b0, 1'b1};

    resetb = 1'b0;
    idle_inputs();
    repeat (3) @(posedge sclk);
    #1;
    cmp("rst.st_valid1", int'(sv1), 0);
    cmp("rst.st_crc_ok1", int'(ok1), 0);
    cmp("rst.st_len1", int'(ln1), 0);
    cmp("rst.busy1", int'(bz1), 0);
    cmp("rst.st_valid4", int'(sv4), 0);
    cmp("rst.flags4", int'({ok4, ru4, gi4, ab4}), 0);
    cmp("rst.busy4", int'(bz4), 0);
    resetb = 1'b1;
    @(posedge sclk); #1;

    // "123456789" with its FCS, one byte per beat.
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    drive(1, 0, 1);
    check_st(1, "check1", mk(1, 1, 0, 0, 13), last_cyc);

    // Same frame, four lanes, last beat keep=1.
    drive(4, 0, 1);
    check_st(4, "check4", mk(1, 1, 0, 0, 13), last_cyc);

    frm[11] = frm[11] ^ 8'hFF;
    drive(4, 0, 1);
    check_st(4, "check4_badfcs", mk(0, 1, 0, 0, 13), last_cyc);

    for (int i = 0; i < 11; i++) begin
      build(tbl[i].n, 1'b0);
      if (tbl[i].bad) frm[tbl[i].n - 2] = frm[tbl[i].n - 2] ^ 8'h10;
      drive(tbl[i].lanes, tbl[i].gaps, 1);
      check_st(tbl[i].lanes, $sformatf("tbl%0d", i),
               mk(tbl[i].exp_ok, tbl[i].exp_runt, tbl[i].exp_giant, 1'b0, tbl[i].exp_len),
               last_cyc);
    end

    // 64-byte then 1519-byte frame with no gap between eof and sof.
    build(64, 1'b1);
    drive(4, 0, 1);
    c1 = last_cyc;
    build(1519, 1'b1);
    drive(4, 0, 1);
    check_st(4, "b2b_64", mk(1, 0, 0, 0, 64), c1);
    check_st(4, "b2b_1519", mk(1, 0, 1, 0, 1519), last_cyc);
    repeat (3) @(posedge sclk);
    #1;
    cmp("hold.st_len", int'(ln4), 1519);
    cmp("hold.st_giant", int'(gi4), 1);
    cmp("hold.st_valid", int'(sv4), 0);

    // 20 bytes with no eof, cut short by the next sof.
    build(20, 1'b1);
    drive(4, 0, 0);
    build(64, 1'b1);
    drive(4, 0, 1);
    check_st(4, "abort", mk(0, 1, 0, 1, 20), first_cyc);
    check_st(4, "after_abort", mk(1, 0, 0, 0, 64), last_cyc);

    build(70, 1'b1);
    drive(1, 1, 1);
    check_st(1, "gaps1", mk(1, 0, 0, 0, 70), last_cyc);

    // Beats without sof while idle are dropped.
    v4 = 1; s4 = 0; e4 = 1; k4 = 3'd2; d4 = $urandom();
    repeat (3) @(posedge sclk);
    #1;
    idle_inputs();
    repeat (3) @(posedge sclk);
    #1;
    cmp("discard.nostatus", mq4.size(), 0);
    cmp("discard.busy", int'(bz4), 0);

    // Reset in the middle of a frame.
    build(40, 1'b1);
    drive(4, 0, 0);
    cmp("midrst.busy_before", int'(bz4), 1);
    resetb = 1'b0;
    @(posedge sclk); #1;
    resetb = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    cmp("midrst.busy_after", int'(bz4), 0);
    cmp("midrst.nostatus", mq4.size(), 0);
    build(80, 1'b1);
    drive(4, 0, 1);
    check_st(4, "after_rst", mk(1, 0, 0, 0, 80), last_cyc);

    for (int r = 0; r < 30; r++) begin
      lanes = ($urandom_range(0, 1) != 0) ? 4 : 1;
      n     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1400, 1600))
                                          : int'($urandom_range(5, 150));
      bad   = ($urandom_range(0, 2) == 0);
      gaps  = ($urandom_range(0, 1) != 0);
      build(n, 1'b1);
      if (bad) begin
        c1 = $urandom_range(0, n - 1);
        frm[c1] = frm[c1] ^ 8'h01;
      end
      e = model();
      drive(lanes, gaps, 1);
      check_st(lanes, $sformatf("rnd%0d", r), e, last_cyc);
    end

    repeat (4) @(posedge sclk);
    #1;
    cmp("extra_status", mq1.size() + mq4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/eth_crc32_rx_chk.md
# eth_crc32_rx_chk

Parametrised Ethernet receive-side frame checker. It computes CRC-32 over 1, 2 or 4 byte lanes per clock and checks the running remainder against the good-frame residue. It also counts frame length and flags runt, giant and aborted frames. It sits after the GMII/MAC receive alignment and feeds one status record per frame to the receive FIFO write controller.

## Interface
- LANES, 1: bytes per beat; legal values 1, 2, 4.
- MIN_LEN, 64: minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1518: maximum legal frame length in bytes, FCS included.
- LEN_W, 14: width of the length counter and length output.

Reset is resetb (asynchronous, active-low); the clock is sclk.

- sclk  in  1  clock.
- resetb  in  1  asynchronous active-low reset.
- in_valid  in  1  beat qualifier.
- in_sof  in  1  first beat of frame; valid only with in_valid.
- in_eof  in  1  last beat of frame; valid only with in_valid.
- in_keep  in  $clog2(LANES)+1  count of valid bytes on an eof beat (1..LANES); non-eof beats are always full.
- din  in  8*LANES  data; lane 0 = din[7:0] is the earliest byte on the wire.
- st_valid  out  1  one-cycle pulse, one per terminated frame.
- st_crc_ok  out  1  remainder equals residue.
- st_runt  out  1  length < MIN_LEN.
- st_giant  out  1  length > MAX_LEN; length saturates.
- st_abort  out  1  frame terminated by a new in_sof before in_eof.
- st_len  out  LEN_W  byte count including FCS.
- busy  out  1  state is FRAME.

## Operation
- CRC parameters:
  - polynomial 0x04C11DB7;
  - init 32'hFFFFFFFF;
  - each byte is processed LSB first (d[0] enters first);
  - no final complement;
  - good-frame residue after data plus FCS = 32'hC704DD7B in register bit order.
- Per beat, the lanes are folded in order 0..LANES-1. On an eof beat, only lanes < in_keep are folded.
- State machine has two states, IDLE and FRAME:
  - IDLE + in_valid & in_sof → FRAME. The CRC is seeded with init, then the beat is folded.
  - FRAME + in_valid → fold the beat and add lanes to the length.
  - Any state + in_valid & in_sof & in_eof → single-beat frame. Status is emitted and the state returns to IDLE.
  - FRAME + in_valid & in_eof → emit status, go to IDLE.
  - FRAME + in_valid & in_sof (no eof) → emit status for the old frame with st_abort=1 and st_crc_ok=0, then restart in FRAME on the new frame in the same cycle.
- IDLE + in_valid without in_sof: the beat is discarded with no status and no state change.
- in_valid low: no update; gaps inside a frame are legal.
- Length counter saturates at 2^LEN_W-1. st_giant is set as soon as the count exceeds MAX_LEN and stays set.
- Status fields hold their values until the next st_valid.

## Timing
- st_* is registered. st_valid and its fields appear on the cycle after the terminating beat (latency 1).
- Back-to-back frames are supported, with the eof beat of one frame immediately followed by the sof beat of the next. The next status follows one cycle after that frame's eof.
- Reset values:
  - all st_* outputs 0, busy 0, state IDLE;
  - CRC 32'hFFFFFFFF, length 0.
- Reset asserted mid-frame discards the frame; no status is emitted after reset.
- in_keep = 0 on an eof beat is treated as LANES.

## Structure
- Package eth_pkg holds:
  - CRC32_POLY, CRC32_INIT and CRC32_RESIDUE;
  - function crc32_byte(c[31:0], d[7:0]) returning the next remainder;
  - the state enum.
- Sub-module crc32_lane_fold is combinational. It takes the remainder, LANES bytes and the keep count, and returns the folded remainder as a chain of crc32_byte instances.
- The top level holds the FSM, the length counter and the status registers.

## Test plan
- LANES=1: sof + "123456789" (0x31..0x39) + FCS 0x26,0x39,0xF4,0xCB + eof → st_crc_ok=1, st_len=13, st_runt=1, st_giant=0, one cycle after eof.
- LANES=4: the same 13 bytes as four beats, the last with in_keep=1 → identical status. With one FCS byte flipped → st_crc_ok=0.
- 64-byte frame with correct FCS, followed with zero gap by a 1519-byte frame → statuses {ok=1, len=64, runt=0} and then {giant=1, len=1519}.
- sof, 20 bytes, then a second sof → abort status {st_abort=1, st_crc_ok=0, st_len=20}. The second frame checks normally.
- Frame with in_valid toggled low every other cycle → same result as the gapless run. resetb pulsed mid-frame → no st_valid, busy=0; the next frame checks correctly.
